// File: rtl/dp_ram2.sv
// Shared-array two-port RAM with a single active port per cycle (cs picks A or B).
// Registered read outputs; writes do not pass through to the outputs.
module dp_ram2 #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 3,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_aout,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] data_bout
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Memory sits in the reset domain so an asynchronous reset discards every stored word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      data_aout <= '0;
      data_bout <= '0;
    end else if (cs) begin
      if (we) mem[addr_a] <= data_a;
      else    data_aout   <= mem[addr_a];
    end else begin
      if (we) mem[addr_b] <= data_b;
      else    data_bout   <= mem[addr_b];
    end
  end

endmodule

// File: tb/tb_dp_ram2.sv
// Directed bench for dp_ram2: each cycle pushes the expected output pair to a
// scoreboard queue, which is popped and compared one time unit after the clock edge.
module tb_dp_ram2;

  localparam int AW = 3;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cs;
  logic          we;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_aout;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] data_b;
  logic [DW-1:0] data_bout;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    string         tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  dp_ram2 #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs        (cs),
    .we        (we),
    .addr_a    (addr_a),
    .data_a    (data_a),
    .data_aout (data_aout),
    .addr_b    (addr_b),
    .data_b    (data_b),
    .data_bout (data_bout)
  );

  always #5 clk = ~clk;

  task automatic expect_out(input logic [DW-1:0] ea, input logic [DW-1:0] eb, input string tag);
    exp_t e;
    e.a = ea;
    e.b = eb;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (data_aout === e.a)
      else begin errors++; $error("FAIL %s data_aout got %0d expected %0d", e.tag, data_aout, e.a); end
    checks++;
    assert (data_bout === e.b)
      else begin errors++; $error("FAIL %s data_bout got %0d expected %0d", e.tag, data_bout, e.b); end
  endtask

  // One clock cycle on the selected port; the inactive port's inputs are driven X.
  task automatic cyc(input logic c, input logic w, input logic [AW-1:0] addr, input logic [DW-1:0] din,
                     input logic [DW-1:0] ea, input logic [DW-1:0] eb, input string tag);
    @(negedge clk);
    cs = c;
    we = w;
    if (c) begin
      addr_a = addr; data_a = din; addr_b = 'x; data_b = 'x;
    end else begin
      addr_b = addr; data_b = din; addr_a = 'x; data_a = 'x;
    end
    expect_out(ea, eb, tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b0; we = 1'b0;
    addr_a = '0; data_a = '0; addr_b = '0; data_b = '0;
    #2;
    expect_out(3'd0, 3'd0, "reset_state");
    check_out();
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh memory reads back zero through port B
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, AW'(i), '0, 3'd0, 3'd0, "b_read_zero");

    // Port A writes 1..5 to 0..4, then reads them back in reverse
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, AW'(i), DW'(i + 1), 3'd0, 3'd0, "a_write");
    for (int i = 4; i >= 0; i--) cyc(1'b1, 1'b0, AW'(i), '0, DW'(i + 1), 3'd0, "a_read");

    // Port B overwrites 0..4 with 0..4; port A holds its last read (1)
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, AW'(i), DW'(i), 3'd1, 3'd0, "b_write");
    for (int i = 4; i >= 0; i--) cyc(1'b0, 1'b0, AW'(i), '0, 3'd1, DW'(i), "b_read");

    cyc(1'b1, 1'b0, 3'd0, '0, 3'd0, 3'd0, "a_sees_b_write");

    // Output holds during a write; next read returns the new word
    cyc(1'b1, 1'b1, 3'd5, 3'd3, 3'd0, 3'd0, "a_write5_3");
    cyc(1'b1, 1'b0, 3'd5, '0,   3'd3, 3'd0, "a_read5_3");
    cyc(1'b1, 1'b1, 3'd5, 3'd6, 3'd3, 3'd0, "a_write_hold");
    cyc(1'b1, 1'b0, 3'd5, '0,   3'd6, 3'd0, "a_read5_6");

    // Top address and wrap back to 0, crossing ports with no turnaround
    cyc(1'b0, 1'b1, 3'd7, 3'd7, 3'd6, 3'd0, "b_write7");
    cyc(1'b1, 1'b0, 3'd7, '0,   3'd7, 3'd0, "a_read7");
    cyc(1'b0, 1'b0, 3'(3'd7 + 3'd1), '0, 3'd7, 3'd0, "b_read_wrap0");
    cyc(1'b1, 1'b1, 3'd6, 3'd2, 3'd7, 3'd0, "a_write6");
    cyc(1'b0, 1'b0, 3'd6, '0,   3'd7, 3'd2, "b_read6_switch");

    // Mid-cycle asynchronous reset clears outputs at once
    #2;
    rst_n = 1'b0;
    #1;
    expect_out(3'd0, 3'd0, "async_reset");
    check_out();
    cyc(1'b1, 1'b1, 3'd1, 3'd7, 3'd0, 3'd0, "write_in_reset");
    cyc(1'b1, 1'b0, 3'd7, '0,   3'd0, 3'd0, "read_in_reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, AW'(i), '0, 3'd0, 3'd0, "a_read_after_reset");
    cyc(1'b0, 1'b0, 3'd6, '0, 3'd0, 3'd0, "b_read6_after_reset");
    cyc(1'b0, 1'b0, 3'd7, '0, 3'd0, 3'd0, "b_read7_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_ram2.md
DP_RAM2 -- requirements
Module: dp_ram2

Interface
REQ-001 Parameter ADDR_W, default 3, address width per port.
REQ-002 Parameter DATA_W, default 3, data word width.
REQ-003 Parameter DEPTH, default 2**ADDR_W, number of words (8 at defaults).
REQ-004 clk  input  1  single clock; all state changes on the rising edge except reset.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cs  input  1  port select: 1 = port A active, 0 = port B active.
REQ-007 we  input  1  write enable of the active port: 1 = write, 0 = read.
REQ-008 addr_a  input  ADDR_W  port A word address.
REQ-009 data_a  input  DATA_W  port A write data.
REQ-010 data_aout  output  DATA_W  port A read data, registered.
REQ-011 addr_b  input  ADDR_W  port B word address.
REQ-012 data_b  input  DATA_W  port B write data.
REQ-013 data_bout  output  DATA_W  port B read data, registered.

Function
REQ-014 The storage SHALL be one shared array of DEPTH words x DATA_W bits, visible to both ports.
REQ-015 Exactly one port SHALL be active per cycle, selected by cs sampled at the rising edge of clk.
REQ-016 With the active port and we=1, the word at that port's address SHALL be written with that port's data at the rising edge.
REQ-017 With the active port and we=0, that port's output SHALL load the word at that port's address at the rising edge, giving 1-cycle read latency.
REQ-018 During a write cycle, the active port's output SHALL hold its previous value; write-through is not provided.
REQ-019 The inactive port SHALL neither write nor update its output; its output SHALL hold its last value.
REQ-020 The inactive port's addr and data inputs SHALL be ignored, and may be X without affecting memory or outputs.
REQ-021 A read of an address written in an earlier cycle SHALL return the newest data, regardless of which port wrote it.
REQ-022 Addresses SHALL be full-range; there is no out-of-range condition, and addr = DEPTH-1 followed by +1 wraps to 0 in the stimulus domain.
REQ-023 Switching cs between consecutive cycles SHALL take effect immediately, with no idle cycle or turnaround.
REQ-024 Two ports cannot write simultaneously, by construction of REQ-015, so no collision logic is required.

Reset
REQ-025 While rst_n=0, data_aout and data_bout SHALL be 0, and all DEPTH memory words SHALL be cleared to 0, asynchronously and independent of clk.
REQ-026 While rst_n=0, writes and reads SHALL be ignored.
REQ-027 Normal operation SHALL resume at the first rising edge of clk after rst_n deasserts.
REQ-028 Reset asserted mid-sequence SHALL discard all prior writes; subsequent reads SHALL return 0 until rewritten.

Verification
REQ-029 Reset, then cs=0, we=0, read addr_b=0..7 -> data_bout=0 for every address, one cycle after each address.
REQ-030 cs=1, we=1, write addr_a=0..4 with data_a=1..5, then cs=1, we=0, read addr_a=4,3,2,1,0 -> data_aout=5,4,3,2,1, each one cycle later; data_bout unchanged throughout.
REQ-031 After REQ-030, cs=0, we=1, write addr_b=0..4 with data_b=0..4, then cs=0, we=0, read addr_b=4..0 -> data_bout=4,3,2,1,0; data_aout holds its last value.
REQ-032 After REQ-031, cs=1, we=0, read addr_a=0 -> data_aout=0, confirming a port B write is visible to port A.
REQ-033 Write via A with we=1 while data_aout=3 -> data_aout stays 3 during the write cycle; a read on the next cycle returns the new word.
REQ-034 Assert rst_n=0 between clock edges after writes -> both outputs go to 0 immediately; after release, reading addresses 0..4 returns 0.
